fpga_host_cmd_axi_bridge: RTL and testbench



---
 rtl/fpga_host_cmd_axi_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_fpga_host_cmd_axi_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_host_cmd_axi_bridge.sv
// Host byte-stream command bridge: framed opcodes in, single-beat AXI4 out,
// AXI responses returned as status/data byte frames.
package fpga_host_cmd_axi_bridge_pkg;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          lock;
    logic [3:0]    cache;
    logic [2:0]    prot;
    logic [3:0]    qos;
    logic [3:0]    region;
    logic [5:0]    atop;
    logic          user;
  } axi_ax_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
    logic            user;
  } axi_w_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          user;
  } axi_b_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic          user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;
endpackage

module fpga_host_cmd_axi_bridge #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter logic [IdWidth-1:0] AxiId = '0,
  parameter type axi_req_t = fpga_host_cmd_axi_bridge_pkg::axi_req_t,
  parameter type axi_rsp_t = fpga_host_cmd_axi_bridge_pkg::axi_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output axi_req_t   axi_req_o,
  input  axi_rsp_t   axi_rsp_i,
  output logic       busy_o
);

  localparam int unsigned NB = DataWidth / 8;
  localparam logic [3:0] LastAddr = 4'd7;
  localparam logic [3:0] LastData = 4'(NB - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, AW_W, B, AR, R, RSP_STATUS, RSP_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        write_q, bad_q, drain_q;
  logic [63:0] addr_q, data_q;
  logic [1:0]  resp_q;
  logic        aw_valid_q, w_valid_q, ar_valid_q;
  logic        b_ready_q, r_ready_q;
  logic        cmd_ready_q, busy_q, rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic        cmd_fire, rsp_fire, aw_fire, w_fire;
  logic        aw_done, w_done, ar_fire, b_fire, r_fire;
  logic        entering;
  logic [3:0]  term;
  logic        unused_rsp;

  assign cmd_fire = cmd_valid_i & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready_i;
  assign aw_fire  = aw_valid_q & axi_rsp_i.aw_ready;
  assign w_fire   = w_valid_q & axi_rsp_i.w_ready;
  assign aw_done  = ~aw_valid_q | axi_rsp_i.aw_ready;
  assign w_done   = ~w_valid_q | axi_rsp_i.w_ready;
  assign ar_fire  = ar_valid_q & axi_rsp_i.ar_ready;
  assign b_fire   = b_ready_q & axi_rsp_i.b_valid;
  assign r_fire   = r_ready_q & axi_rsp_i.r_valid;
  assign entering = state_d != state_q;
  assign term     = (state_q == ADDR) ? LastAddr : LastData;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (cmd_fire)
          state_d = (cmd_data_i == 8'h01 || cmd_data_i == 8'h02)
                    ? ADDR : RSP_STATUS;
      ADDR:
        if (cmd_fire && cnt_q == LastAddr)
          state_d = write_q ? DATA : AR;
      DATA:
        if (cmd_fire && cnt_q == LastData) state_d = AW_W;
      AW_W:
        if (aw_done && w_done) state_d = B;
      B:
        if (b_fire) state_d = RSP_STATUS;
      AR:
        if (ar_fire) state_d = R;
      R:
        if (r_fire && axi_rsp_i.r.last) state_d = RSP_STATUS;
      RSP_STATUS:
        if (rsp_fire)
          state_d = (write_q || bad_q) ? IDLE : RSP_DATA;
      RSP_DATA:
        if (rsp_fire && cnt_q == LastData) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      bad_q       <= 1'b0;
      drain_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= state_d inside {IDLE, ADDR, DATA};
      busy_q      <= state_d != IDLE;
      b_ready_q   <= state_d == B;
      r_ready_q   <= state_d == R;
      if (entering) cnt_q <= '0;
      else if ((cmd_fire || rsp_fire) && cnt_q != term)
        cnt_q <= cnt_q + 4'd1;
      if (state_q == IDLE && cmd_fire) begin
        write_q <= cmd_data_i == 8'h01;
        bad_q   <= !(cmd_data_i == 8'h01 || cmd_data_i == 8'h02);
      end
      // Shift-in leaves the little-endian frame value in the top bytes
      if (state_q == ADDR && cmd_fire)
        addr_q <= {cmd_data_i, addr_q[63:8]};
      if (state_q == DATA && cmd_fire)
        data_q <= {cmd_data_i, data_q[63:8]};
      if (entering && state_d == AW_W) begin
        aw_valid_q <= 1'b1;
        w_valid_q  <= 1'b1;
      end else begin
        if (aw_fire) aw_valid_q <= 1'b0;
        if (w_fire) w_valid_q <= 1'b0;
      end
      if (entering && state_d == AR) ar_valid_q <= 1'b1;
      else if (ar_fire) ar_valid_q <= 1'b0;
      if (entering && state_d == R) drain_q <= 1'b0;
      else if (r_fire && !axi_rsp_i.r.last) drain_q <= 1'b1;
      if (r_fire && !drain_q) begin
        data_q <= 64'(axi_rsp_i.r.data);
        resp_q <= axi_rsp_i.r.resp;
      end
      if (entering && state_d == RSP_STATUS) begin
        rsp_valid_q <= 1'b1;
        unique case (1'b1)
          (state_q == IDLE): rsp_data_q <= 8'hEE;
          (state_q == B):    rsp_data_q <= {6'b0, axi_rsp_i.b.resp};
          default:
            rsp_data_q <= {6'b0, drain_q ? resp_q : axi_rsp_i.r.resp};
        endcase
      end else if (rsp_fire) begin
        if (state_d == IDLE) rsp_valid_q <= 1'b0;
        else begin
          rsp_data_q <= data_q[7:0];
          data_q     <= data_q >> 8;
        end
      end
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AxiId;
    axi_req_o.aw.addr  = addr_q[AddrWidth-1:0];
    axi_req_o.aw.size  = 3'($clog2(NB));
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = data_q[63 -: DataWidth];
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.id    = AxiId;
    axi_req_o.ar.addr  = addr_q[AddrWidth-1:0];
    axi_req_o.ar.size  = 3'($clog2(NB));
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = busy_q;
  assign unused_rsp  = ^{axi_rsp_i.b.id, axi_rsp_i.b.user,
                         axi_rsp_i.r.id, axi_rsp_i.r.user};

endmodule

// File: tb/tb_fpga_host_cmd_axi_bridge.sv
// Scoreboard bench for the host command bridge: stimulus pushes expected
// AXI beats and response bytes, slave/monitor processes pop and compare.
module tb_fpga_host_cmd_axi_bridge;
  import fpga_host_cmd_axi_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] cmd_data;
  logic       cmd_valid, cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid, rsp_ready;
  axi_req_t   req;
  axi_rsp_t   rsp;
  logic       busy;

  always #5 clk = ~clk;

  fpga_host_cmd_axi_bridge dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .axi_req_o(req), .axi_rsp_i(rsp), .busy_o(busy)
  );

  int n_chk = 0, n_fail = 0;
  logic [47:0] exp_aw[$], exp_ar[$];
  logic [63:0] exp_w[$];
  logic [7:0]  exp_rsp[$];
  int aw_count = 0, w_count = 0, ar_count = 0, viol = 0;

  int          aw_delay = 0, r_extra = 0;
  logic [1:0]  b_resp = 0, r_resp = 0;
  logic [63:0] r_data = 0, r_data2 = 0;
  bit          r_hold = 0, rsp_toggle = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // AXI slave model and AXI-side checker, evaluated on the falling edge
  initial begin
    int aw_wait = 0, r_left = 0;
    bit aw_got = 0, w_got = 0, b_todo = 0, b_pend = 0;
    bit r_todo = 0, r_pend = 0, pawv = 0, pawhs = 0;
    logic [47:0] pawa = 0;
    rsp = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        rsp = '0;
        aw_wait = 0; aw_got = 0; w_got = 0; b_todo = 0; b_pend = 0;
        r_todo = 0; r_pend = 0; r_left = 0; pawv = 0; pawhs = 0;
      end else begin
        if (b_pend) begin rsp.b_valid = 0; b_pend = 0; end
        if (b_todo && !rsp.b_valid) begin
          rsp.b_valid = 1; rsp.b.resp = b_resp; b_todo = 0;
        end
        b_pend = rsp.b_valid && req.b_ready;
        if (r_pend) begin
          r_pend = 0;
          if (r_left > 0) begin
            r_left--;
            rsp.r.data = r_data2;
            rsp.r.last = (r_left == 0);
          end else rsp.r_valid = 0;
        end else if (r_todo && !r_hold && !rsp.r_valid) begin
          rsp.r_valid = 1; rsp.r.data = r_data; rsp.r.resp = r_resp;
          rsp.r.last = (r_extra == 0); r_left = r_extra; r_todo = 0;
        end
        r_pend = rsp.r_valid && req.r_ready;
        if (pawv && !pawhs && (!req.aw_valid || req.aw.addr != pawa))
          viol++;
        if (req.aw_valid) begin
          rsp.aw_ready = (aw_wait >= aw_delay); aw_wait++;
        end else begin
          rsp.aw_ready = 0; aw_wait = 0;
        end
        pawv = req.aw_valid; pawa = req.aw.addr;
        pawhs = req.aw_valid && rsp.aw_ready;
        if (pawhs) begin
          aw_count++; aw_got = 1; aw_wait = 0;
          if (exp_aw.size() == 0) fail("aw_unexpected");
          else chk("aw_addr", req.aw.addr, exp_aw.pop_front());
          chk("aw_fields", {req.aw.len, req.aw.size, req.aw.burst, req.aw.id},
              {8'd0, 3'd3, 2'd1, 4'd0});
        end
        rsp.w_ready = req.w_valid;
        if (req.w_valid) begin
          w_count++; w_got = 1;
          if (exp_w.size() == 0) fail("w_unexpected");
          else chk("w_data", req.w.data, exp_w.pop_front());
          chk("w_strb_last", {req.w.strb, req.w.last}, {8'hFF, 1'b1});
        end
        if (aw_got && w_got) begin b_todo = 1; aw_got = 0; w_got = 0; end
        rsp.ar_ready = req.ar_valid;
        if (req.ar_valid) begin
          ar_count++; r_todo = 1;
          if (exp_ar.size() == 0) fail("ar_unexpected");
          else chk("ar_addr", req.ar.addr, exp_ar.pop_front());
          chk("ar_fields", {req.ar.len, req.ar.size, req.ar.burst, req.ar.id},
              {8'd0, 3'd3, 2'd1, 4'd0});
        end
      end
    end
  end

  // Response byte monitor
  initial begin
    bit pv = 0, ph = 0, hs;
    logic [7:0] pd = 0;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pv = 0; ph = 0;
      end else begin
        rsp_ready = rsp_toggle ? ~rsp_ready : 1'b1;
        if (pv && !ph && (!rsp_valid || rsp_data != pd)) viol++;
        hs = rsp_valid && rsp_ready;
        if (hs) begin
          if (exp_rsp.size() == 0) fail("rsp_unexpected");
          else chk("rsp_byte", rsp_data, exp_rsp.pop_front());
        end
        pv = rsp_valid; pd = rsp_data; ph = hs;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    cmd_data = b;
    cmd_valid = 1;
    while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
    if (!cmd_ready) fail("cmd_timeout");
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [63:0] a,
                            input logic [63:0] d, input bit wr);
    send_byte(op);
    for (int i = 0; i < 8; i++) send_byte(a[i*8 +: 8]);
    if (wr) begin
      for (int i = 0; i < 8; i++) send_byte(d[i*8 +: 8]);
      chk("aw_w_latency", {req.aw_valid, req.w_valid}, 2'b11);
    end else chk("ar_latency", req.ar_valid, 1'b1);
  endtask

  task automatic exp_write(input logic [63:0] a, input logic [63:0] d,
                           input logic [1:0] br);
    exp_aw.push_back(a[47:0]);
    exp_w.push_back(d);
    exp_rsp.push_back({6'b0, br});
    b_resp = br;
  endtask

  task automatic exp_read(input logic [63:0] a, input logic [63:0] d,
                          input logic [1:0] rr);
    exp_ar.push_back(a[47:0]);
    exp_rsp.push_back({6'b0, rr});
    for (int i = 0; i < 8; i++) exp_rsp.push_back(d[i*8 +: 8]);
    r_data = d;
    r_resp = rr;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!(exp_rsp.size() == 0 && !busy) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) fail({name, "_timeout"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i = 1; cmd_valid = 0; cmd_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_axi", {req.aw_valid, req.w_valid, req.ar_valid,
                    req.b_ready, req.r_ready}, 0);
    rst_i = 0;

    exp_write(64'h1000, 64'h12345678_DEADBEEF, 2'b00);
    send_frame(8'h01, 64'h1000, 64'h12345678_DEADBEEF, 1);
    wait_done("write");

    exp_read(64'h1000, 64'h12345678_DEADBEEF, 2'b00);
    send_frame(8'h02, 64'h1000, 64'h0, 0);
    wait_done("read");

    exp_write(64'h1008, 64'h0, 2'b10);
    send_frame(8'h01, 64'h1008, 64'h0, 1);
    wait_done("write_slverr");

    rsp_toggle = 1;
    exp_read(64'h1010, 64'hCAFE_F00D_0BAD_BEEF, 2'b11);
    send_frame(8'h02, 64'h1010, 64'h0, 0);
    wait_done("read_decerr");
    rsp_toggle = 0;

    exp_rsp.push_back(8'hEE);
    send_byte(8'h7F);
    wait_done("bad_opcode");
    exp_read(64'h2000, 64'h0011_2233_4455_6677, 2'b00);
    send_frame(8'h02, 64'h2000, 64'h0, 0);
    wait_done("read_after_bad");

    aw_delay = 5; rsp_toggle = 1;
    exp_write(64'hFFFF_0000_0000_0008, 64'h0807_0605_0403_0201, 2'b00);
    send_frame(8'h01, 64'hFFFF_0000_0000_0008, 64'h0807_0605_0403_0201, 1);
    wait_done("write_backpressure");
    aw_delay = 0; rsp_toggle = 0;

    r_extra = 1; r_data2 = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_read(64'h3000, 64'hA1B2_C3D4_E5F6_0718, 2'b00);
    send_frame(8'h02, 64'h3000, 64'h0, 0);
    wait_done("read_multibeat");
    r_extra = 0;

    r_hold = 1;
    exp_ar.push_back(48'h4000);
    send_frame(8'h02, 64'h4000, 64'h0, 0);
    t = 0;
    while (!req.r_ready && t < 100) begin @(negedge clk); t++; end
    if (!req.r_ready) fail("reach_r_timeout");
    rst_i = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_axi", {req.aw_valid, req.w_valid, req.ar_valid,
                        req.b_ready, req.r_ready}, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 0;
    r_hold = 0;

    exp_write(64'h5000, 64'h1, 2'b00);
    send_frame(8'h01, 64'h5000, 64'h1, 1);
    wait_done("write_after_reset");

    repeat (5) @(negedge clk);
    chk("aw_count", aw_count, 4);
    chk("w_count", w_count, 4);
    chk("ar_count", ar_count, 5);
    chk("stability_violations", viol, 0);
    chk("leftover_expects",
        exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
